// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S transmit controller and its clock generator.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } i2s_ctrl_state_t;

  localparam int unsigned I2S_DATA_W = 8;
  localparam int unsigned I2S_DIV_W  = 8;

endpackage

// File: rtl/i2s_clkgen.sv
// Bit-clock generator: divides clk by 2*(div_q+1) while run is high and flags sck edges.
module i2s_clkgen #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [DIV_W-1:0] div_q,
  output logic             sck,
  output logic             fe,
  output logic             re
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             sck_q, sck_d;
  logic             tc;

  always_comb begin
    div_cnt_d = div_cnt_q;
    sck_d     = sck_q;
    tc        = run && (div_cnt_q == div_q);
    if (!run) begin
      // Held cleared outside RUN so the first half-period after a start is full length.
      div_cnt_d = '0;
      sck_d     = 1'b0;
    end else if (tc) begin
      div_cnt_d = '0;
      sck_d     = ~sck_q;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      sck_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sck_q     <= sck_d;
    end
  end

  assign sck = sck_q;
  assign fe  = tc && sck_q;
  assign re  = tc && !sck_q;

endmodule

// File: rtl/i2s_tx_ctrl.sv
// I2S transmit sequencer: one-entry sample holding register, frame FSM and bit/word clocks
// feeding i2s_core with per-frame stable data.
module i2s_tx_ctrl
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W = I2S_DATA_W,
  parameter int unsigned DIV_W  = I2S_DIV_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DIV_W-1:0]  div,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  input  logic              underflow_clr,
  output logic              sck,
  output logic              ws,
  output logic [DATA_W-1:0] data_left,
  output logic [DATA_W-1:0] data_right,
  output logic              frame_strobe,
  output logic              underflow,
  output logic              busy
);

  localparam int unsigned        BitW      = $clog2(2 * DATA_W);
  localparam logic [BitW-1:0]    HalfLast  = BitW'(DATA_W - 1);
  localparam logic [BitW-1:0]    FrameLast = BitW'(2 * DATA_W - 1);

  i2s_ctrl_state_t   state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DATA_W-1:0] pend_left_q, pend_left_d, pend_right_q, pend_right_d;
  logic              pend_v_q, pend_v_d;
  logic [DATA_W-1:0] data_left_q, data_left_d, data_right_q, data_right_d;
  logic              ws_q, ws_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              underflow_q, underflow_d;
  logic              strobe_q, strobe_d;
  logic              run, fe, re, accept, load, uf_set;

  i2s_clkgen #(
    .DIV_W (DIV_W)
  ) u_clkgen (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .div_q (div_q),
    .sck   (sck),
    .fe    (fe),
    .re    (re)
  );

  assign run    = (state_q == RUN);
  assign accept = in_valid && !pend_v_q;

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    pend_left_d  = pend_left_q;
    pend_right_d = pend_right_q;
    pend_v_d     = pend_v_q;
    data_left_d  = data_left_q;
    data_right_d = data_right_q;
    ws_d         = ws_q;
    bit_cnt_d    = bit_cnt_q;
    underflow_d  = underflow_q;
    strobe_d     = 1'b0;
    load         = 1'b0;
    uf_set       = 1'b0;

    case (state_q)
      IDLE: begin
        ws_d      = 1'b0;
        bit_cnt_d = '0;
        if (enable) begin
          state_d = PRIME;
          div_d   = div;
        end
      end
      PRIME: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (pend_v_q) begin
          state_d   = RUN;
          load      = 1'b1;
          ws_d      = 1'b0;
          bit_cnt_d = '0;
        end
      end
      RUN: begin
        // ws and data only move on the sck falling edge, keeping them stable at the rise.
        if (fe) begin
          if (bit_cnt_q == FrameLast) begin
            bit_cnt_d = '0;
            ws_d      = 1'b0;
            if (!enable) begin
              state_d = IDLE;
            end else if (pend_v_q) begin
              load = 1'b1;
            end else begin
              uf_set = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == HalfLast) begin
              ws_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      data_left_d  = pend_left_q;
      data_right_d = pend_right_q;
      pend_v_d     = 1'b0;
      strobe_d     = 1'b1;
    end
    if (uf_set) begin
      data_left_d  = '0;
      data_right_d = '0;
      strobe_d     = 1'b1;
    end
    if (accept) begin
      pend_left_d  = in_left;
      pend_right_d = in_right;
      pend_v_d     = 1'b1;
    end
    if (underflow_clr) begin
      underflow_d = 1'b0;
    end
    if (uf_set) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      div_q        <= '0;
      pend_left_q  <= '0;
      pend_right_q <= '0;
      pend_v_q     <= 1'b0;
      data_left_q  <= '0;
      data_right_q <= '0;
      ws_q         <= 1'b0;
      bit_cnt_q    <= '0;
      underflow_q  <= 1'b0;
      strobe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      pend_left_q  <= pend_left_d;
      pend_right_q <= pend_right_d;
      pend_v_q     <= pend_v_d;
      data_left_q  <= data_left_d;
      data_right_q <= data_right_d;
      ws_q         <= ws_d;
      bit_cnt_q    <= bit_cnt_d;
      underflow_q  <= underflow_d;
      strobe_q     <= strobe_d;
    end
  end

  // A terminal count is either a rise or a fall of sck, never both.
  edge_excl_a: assert property (@(posedge clk) disable iff (reset) !(fe && re));

  assign in_ready     = !pend_v_q;
  assign ws           = ws_q;
  assign data_left    = data_left_q;
  assign data_right   = data_right_q;
  assign frame_strobe = strobe_q;
  assign underflow    = underflow_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Directed bench for i2s_tx_ctrl: a scoreboard checks every frame_strobe against queued pairs,
// while the stimulus process checks clock/word timing, stop behaviour and reset.
module tb_i2s_tx_ctrl;

  logic       clk = 1'b0;
  logic       reset, enable, in_valid, in_ready, underflow_clr;
  logic [7:0] div, in_left, in_right, data_left, data_right;
  logic       sck, ws, frame_strobe, underflow, busy;

  typedef struct {
    logic [7:0] l;
    logic [7:0] r;
    logic       uf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   t0, t1, t2, te;

  i2s_tx_ctrl #(
    .DATA_W (8),
    .DIV_W  (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .div           (div),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_left       (in_left),
    .in_right      (in_right),
    .underflow_clr (underflow_clr),
    .sck           (sck),
    .ws            (ws),
    .data_left     (data_left),
    .data_right    (data_right),
    .frame_strobe  (frame_strobe),
    .underflow     (underflow),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Scoreboard monitor: every data load or underflow strobe must match the next queued entry.
  always @(negedge clk) begin
    if (frame_strobe) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_strobe: got %0h/%0h uf=%0b, expected no strobe", data_left,
                 data_right, underflow);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({data_left, data_right, underflow} !== {e.l, e.r, e.uf}) begin
          errors++;
          $display("FAIL sb_frame: got %0h/%0h uf=%0b, expected %0h/%0h uf=%0b", data_left,
                   data_right, underflow, e.l, e.r, e.uf);
        end
      end
    end
  end

  task automatic expect_frame(input logic [7:0] l, input logic [7:0] r, input logic uf);
    exp_t e;
    e.l  = l;
    e.r  = r;
    e.uf = uf;
    exp_q.push_back(e);
  endtask

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] l, input logic [7:0] r);
    int n = 0;
    in_valid = 1'b1;
    in_left  = l;
    in_right = r;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("in_ready_low_when_pending", in_ready, 0);
  endtask

  task automatic wait_strobe(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_strobe && n < 300);
    chk(nm, frame_strobe, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; div = 8'd0; in_valid = 1'b0;
    in_left = 8'd0; in_right = 8'd0; underflow_clr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_sck", sck, 0);
    chk("rst_ws", ws, 0);
    chk("rst_data", {data_left, data_right}, 0);
    chk("rst_strobe", frame_strobe, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);

    // Basic frame at div=0, then underflow handling
    div = 8'd0;
    push(8'hA5, 8'h3C);
    expect_frame(8'hA5, 8'h3C, 1'b0);
    enable = 1'b1;
    te = cyc;
    wait_strobe("basic_strobe");
    t0 = cyc;
    chk("basic_latency", 32'(t0 - te), 2);
    chk("basic_busy", busy, 1);
    at_cyc(t0 + 1);  chk("basic_sck_hi", sck, 1);
    at_cyc(t0 + 2);  chk("basic_sck_lo", sck, 0);
    at_cyc(t0 + 15); chk("basic_ws_left", ws, 0);
    at_cyc(t0 + 16); chk("basic_ws_rise", ws, 1);
    at_cyc(t0 + 31); chk("basic_ws_right", ws, 1);
    chk("basic_no_early_strobe", frame_strobe, 0);
    expect_frame(8'h00, 8'h00, 1'b1);
    at_cyc(t0 + 32);
    chk("uf_strobe", frame_strobe, 1);
    chk("uf_ws_fall", ws, 0);
    chk("uf_set", underflow, 1);
    underflow_clr = 1'b1;
    at_cyc(t0 + 33);
    chk("uf_cleared", underflow, 0);
    underflow_clr = 1'b0;
    at_cyc(t0 + 63);
    underflow_clr = 1'b1;
    expect_frame(8'h00, 8'h00, 1'b1);
    at_cyc(t0 + 64);
    chk("uf_set_beats_clr", underflow, 1);
    at_cyc(t0 + 65);
    underflow_clr = 1'b0;
    chk("uf_cleared_again", underflow, 0);

    // Back-to-back streaming
    expect_frame(8'h11, 8'h22, 1'b0);
    push(8'h11, 8'h22);
    expect_frame(8'h33, 8'h44, 1'b0);
    push(8'h33, 8'h44);
    expect_frame(8'h55, 8'h66, 1'b0);
    push(8'h55, 8'h66);
    at_cyc(t0 + 161);
    chk("stream_no_underflow", underflow, 0);

    // Graceful stop from bit_cnt=5
    at_cyc(t0 + 170);
    enable = 1'b0;
    at_cyc(t0 + 191);
    chk("stop_still_busy", busy, 1);
    at_cyc(t0 + 192);
    chk("stop_busy", busy, 0);
    chk("stop_sck", sck, 0);
    chk("stop_ws", ws, 0);
    chk("stop_no_strobe", frame_strobe, 0);
    chk("stop_data_held", {data_left, data_right}, 16'h5566);
    chk("stop_no_underflow", underflow, 0);

    // Divider latch: div=3 held for the run even after div changes
    div = 8'd3;
    expect_frame(8'h77, 8'h88, 1'b0);
    push(8'h77, 8'h88);
    enable = 1'b1;
    te = cyc;
    wait_strobe("div3_strobe");
    t1 = cyc;
    div = 8'd0;
    at_cyc(t1 + 3);   chk("div3_sck_lo", sck, 0);
    at_cyc(t1 + 4);   chk("div3_sck_rise", sck, 1);
    at_cyc(t1 + 7);   chk("div3_sck_hi", sck, 1);
    at_cyc(t1 + 8);   chk("div3_sck_fall", sck, 0);
    at_cyc(t1 + 63);  chk("div3_ws_left", ws, 0);
    at_cyc(t1 + 64);  chk("div3_ws_rise", ws, 1);
    enable = 1'b0;
    at_cyc(t1 + 127); chk("div3_still_busy", busy, 1);
    at_cyc(t1 + 128); chk("div3_stop_busy", busy, 0);

    // Restart picks up div=0
    expect_frame(8'h99, 8'hAA, 1'b0);
    push(8'h99, 8'hAA);
    enable = 1'b1;
    wait_strobe("restart_strobe");
    t2 = cyc;
    at_cyc(t2 + 1); chk("restart_sck_hi", sck, 1);
    at_cyc(t2 + 2); chk("restart_sck_lo", sck, 0);

    // Reset mid-frame with a pending pair, which must be discarded
    push(8'hBB, 8'hCC);
    at_cyc(t2 + 18);
    reset  = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_sck", sck, 0);
    chk("mid_rst_ws", ws, 0);
    chk("mid_rst_data", {data_left, data_right}, 0);
    chk("mid_rst_strobe", frame_strobe, 0);
    chk("mid_rst_underflow", underflow, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    repeat (5) @(negedge clk);
    chk("post_rst_idle", busy, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
